// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// operation codes and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        WRITE,
        DZERO
    } stateT;

endpackage

// File: rtl/muldiv_datapath.sv
// Arithmetic core of the sequencer: radix-2 Booth multiplier and restoring
// divider sharing one iteration counter. Executes one step per stepEn and
// presents sign-corrected HI/LO results for the operation last loaded.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             loadMul,
    input  logic             loadDiv,
    input  logic             stepEn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             lastStep,
    output logic [WIDTH-1:0] hiResult,
    output logic [WIDTH-1:0] loResult
);

    // The upper half carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    logic [AW-1:0]    accReg;
    logic [WIDTH-1:0] mcandReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [CW-1:0]    countReg;
    logic             isDivReg;
    logic             qSignReg;
    logic             rSignReg;

    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   aExt;
    logic [WIDTH:0]   upperSum;
    logic [AW-1:0]    boothNext;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   divExt;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;

    // Magnitudes for the divider; the most negative value maps to 2^(WIDTH-1)
    // which is still representable as an unsigned WIDTH-bit number.
    assign aMag = A[WIDTH-1] ? -A : A;
    assign bMag = B[WIDTH-1] ? -B : B;

    // One Booth step: add/subtract the multiplicand by the low bit pair, then shift right arithmetically
    always_comb begin
        upper    = accReg[AW-1:WIDTH+1];
        aExt     = {mcandReg[WIDTH-1], mcandReg};
        upperSum = upper;
        case (accReg[1:0])
            2'b01:   upperSum = upper + aExt;
            2'b10:   upperSum = upper - aExt;
            default: upperSum = upper;
        endcase
        boothNext = {upperSum[WIDTH], upperSum, accReg[WIDTH:1]};
    end

    // One restoring step: shift {rem, quo} left and keep the trial subtraction when it fits
    always_comb begin
        shifted = {remReg, quoReg[WIDTH-1]};
        divExt  = {1'b0, divisorReg};
        diff    = shifted - divExt;
        fits    = (shifted >= divExt);
        remNext = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quoNext = {quoReg[WIDTH-2:0], fits};
    end

    // Operand latch on load, one iteration per enabled cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            accReg     <= '0;
            mcandReg   <= '0;
            divisorReg <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            countReg   <= '0;
            isDivReg   <= 1'b0;
            qSignReg   <= 1'b0;
            rSignReg   <= 1'b0;
        end else if (loadMul) begin
            mcandReg <= A;
            accReg   <= {{(WIDTH + 1){1'b0}}, B, 1'b0};
            countReg <= '0;
            isDivReg <= 1'b0;
            qSignReg <= 1'b0;
            rSignReg <= 1'b0;
        end else if (loadDiv) begin
            quoReg     <= aMag;
            divisorReg <= bMag;
            remReg     <= '0;
            qSignReg   <= A[WIDTH-1] ^ B[WIDTH-1];
            rSignReg   <= A[WIDTH-1];
            countReg   <= '0;
            isDivReg   <= 1'b1;
        end else if (stepEn) begin
            countReg <= countReg + CW'(1);
            if (isDivReg) begin
                remReg <= remNext;
                quoReg <= quoNext;
            end else begin
                accReg <= boothNext;
            end
        end
    end

    assign lastStep = (countReg == CW'(WIDTH - 1));

    // Quotient takes the XOR of operand signs, remainder follows the dividend
    assign hiResult = isDivReg ? (rSignReg ? -remReg : remReg) : accReg[2*WIDTH:WIDTH+1];
    assign loResult = isDivReg ? (qSignReg ? -quoReg : quoReg) : accReg[WIDTH:1];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/DIV sequencer: accepts one request in IDLE, runs WIDTH
// iterations in the datapath, then issues a one-cycle completion (with HI/LO
// load strobes) or a one-cycle divide-by-zero indication.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HighOut,
    output logic [WIDTH-1:0] LowOut,
    output logic             RegHighW,
    output logic             RegLowW
);

    stateT stateReg;
    logic  busyReg;
    logic  doneReg;
    logic  divZeroReg;
    logic  regHighWReg;
    logic  regLowWReg;

    logic             loadMul;
    logic             loadDiv;
    logic             stepEn;
    logic             lastStep;
    logic             divisorZero;
    logic [WIDTH-1:0] hiResult;
    logic [WIDTH-1:0] loResult;

    assign divisorZero = (B == '0);
    assign loadMul     = (stateReg == IDLE) && Start && (Op == OP_MULT);
    assign loadDiv     = (stateReg == IDLE) && Start && (Op == OP_DIV) && !divisorZero;
    assign stepEn      = (stateReg == MULT) || (stateReg == DIV);

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) datapath (
        .Clk     (Clk),
        .Reset   (Reset),
        .loadMul (loadMul),
        .loadDiv (loadDiv),
        .stepEn  (stepEn),
        .A       (A),
        .B       (B),
        .lastStep(lastStep),
        .hiResult(hiResult),
        .loResult(loResult)
    );

    // Control FSM; strobes are registered so they line up with the state they describe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg    <= IDLE;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            divZeroReg  <= 1'b0;
            regHighWReg <= 1'b0;
            regLowWReg  <= 1'b0;
        end else begin
            doneReg     <= 1'b0;
            divZeroReg  <= 1'b0;
            regHighWReg <= 1'b0;
            regLowWReg  <= 1'b0;
            unique case (stateReg)
                IDLE: begin
                    if (Start) begin
                        busyReg <= 1'b1;
                        if (Op == OP_MULT) begin
                            stateReg <= MULT;
                        end else if (!divisorZero) begin
                            stateReg <= DIV;
                        end else begin
                            stateReg   <= DZERO;
                            doneReg    <= 1'b1;
                            divZeroReg <= 1'b1;
                        end
                    end
                end
                MULT, DIV: begin
                    if (lastStep) begin
                        stateReg    <= WRITE;
                        doneReg     <= 1'b1;
                        regHighWReg <= 1'b1;
                        regLowWReg  <= 1'b1;
                    end
                end
                WRITE, DZERO: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
                default: begin
                    stateReg <= IDLE;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy     = busyReg;
    assign Done     = doneReg;
    assign DivZero  = divZeroReg;
    assign RegHighW = regHighWReg;
    assign RegLowW  = regLowWReg;

    // Results are only driven during the write-back cycle
    assign HighOut = (stateReg == WRITE) ? hiResult : '0;
    assign LowOut  = (stateReg == WRITE) ? loResult : '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for the ignored-restart and mid-operation reset cases.
module tb_muldiv_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] HighOut;
    logic [31:0] LowOut;
    logic        RegHighW;
    logic        RegLowW;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HighOut (HighOut),
        .LowOut  (LowOut),
        .RegHighW(RegHighW),
        .RegLowW (RegLowW)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vecT;

    vecT vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Signed arithmetic reference: product, truncating quotient, remainder with dividend sign
    function automatic void refModel(input logic op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        dz = 1'b0;
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Issue one request and follow it to completion; pulseAt>0 re-asserts Start in that cycle
    task automatic runOp(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz,
                         input int pulseAt, input string tag);
        int          expCyc;
        int          doneCyc;
        int          doneCnt;
        int          busyBad;
        int          leakBad;
        logic [31:0] gotHi;
        logic [31:0] gotLo;
        logic        gotDz;
        logic        gotHw;
        logic        gotLw;
        expCyc  = (op == 1'b1 && b == 32'd0) ? 1 : 33;
        doneCyc = 0;
        doneCnt = 0;
        busyBad = 0;
        leakBad = 0;
        gotHi   = '0;
        gotLo   = '0;
        gotDz   = 1'b0;
        gotHw   = 1'b0;
        gotLw   = 1'b0;
        @(negedge Clk);
        check({tag, " idle_before"}, {Busy, Done}, 2'b00);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        for (int cyc = 1; cyc <= expCyc; cyc++) begin
            if (cyc == pulseAt) begin
                Start = 1'b1;
                Op    = 1'b0;
            end
            @(negedge Clk);
            if (Busy !== 1'b1) busyBad++;
            if (Done === 1'b1) begin
                doneCnt++;
                if (doneCyc == 0) begin
                    doneCyc = cyc;
                    gotHi   = HighOut;
                    gotLo   = LowOut;
                    gotDz   = DivZero;
                    gotHw   = RegHighW;
                    gotLw   = RegLowW;
                end
            end else if (HighOut !== 32'd0 || LowOut !== 32'd0 || DivZero !== 1'b0
                         || RegHighW !== 1'b0 || RegLowW !== 1'b0) begin
                leakBad++;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0;
        end
        $display("%s op=%0d a=%h b=%h hi=%h lo=%h dz=%0d done_cycle=%0d",
                 tag, op, a, b, gotHi, gotLo, gotDz, doneCyc);
        check({tag, " done_cycle"}, doneCyc, expCyc);
        check({tag, " done_count"}, doneCnt, 1);
        check({tag, " busy"}, busyBad, 0);
        check({tag, " quiet_outputs"}, leakBad, 0);
        check({tag, " high"}, gotHi, expHi);
        check({tag, " low"}, gotLo, expLo);
        check({tag, " divzero"}, gotDz, expDz);
        check({tag, " strobes"}, {gotHw, gotLw}, expDz ? 2'b00 : 2'b11);
    endtask

    initial begin
        logic [31:0] rHi;
        logic [31:0] rLo;
        logic        rDz;
        logic        rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int          strobeSeen;

        vecs[0] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5] = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[6] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};

        Reset = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_state", {Busy, Done, DivZero, RegHighW, RegLowW, HighOut, LowOut},
              {5'b0, 64'd0});
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                  0, $sformatf("vec%0d", i));
        end

        // Start in cycle 10 of a MULT is ignored; the next request lands in cycle 34
        runOp(1'b0, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFFFF, 32'hFFFFD8F0, 1'b0, 10, "restart_ignored");
        runOp(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, "start_cycle34");

        // Reset in cycle 15 of a DIV aborts it with no strobes
        strobeSeen = 0;
        @(negedge Clk);
        Start = 1'b1;
        Op    = 1'b1;
        A     = 32'd100;
        B     = 32'd7;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (cyc == 15) Reset = 1'b1;
            @(negedge Clk);
            if (Done || RegHighW || RegLowW || DivZero) strobeSeen++;
            if (cyc == 14) check("abort busy_mid_div", Busy, 1'b1);
            @(posedge Clk);
            #1;
        end
        Reset = 1'b0;
        @(negedge Clk);
        $display("abort_div busy=%0d done=%0d hi=%h lo=%h", Busy, Done, HighOut, LowOut);
        check("abort outputs_after_reset", {Busy, Done, DivZero, RegHighW, RegLowW, HighOut, LowOut},
              {5'b0, 64'd0});
        check("abort strobes_seen", strobeSeen, 0);
        runOp(1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, "after_abort");

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rOp = 1'($urandom_range(0, 1));
            rA  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rB = 32'd0;
                1:       rB = 32'hFFFFFFFF;
                2:       rB = 32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            refModel(rOp, rA, rB, rHi, rLo, rDz);
            runOp(rOp, rA, rB, rHi, rLo, rDz, 0, $sformatf("rand%0d", i));
        end

        @(negedge Clk);
        check("final_idle", {Busy, Done}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
